axioma_adc_seq: RTL and testbench

Parametrised multi-channel ADC scan sequencer for the AxiomaCore-328 peripheral bus. It steps through a programmable channel mask and timestamps nothing but tags every result with its channel number. Results are pushed into a result FIFO, so software can drain several conversions per interrupt. It sits beside the legacy 10-bit ADC controller on the same 6-bit I/O bus. Conversion data comes from an external sampled-value bus: an analog front end in silicon, or a model in simulation.

---
 rtl/axioma_adc_seq_if.sv | 37 +++
 rtl/axioma_adc_seq.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_axioma_adc_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axioma_adc_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axioma_adc_seq_if
// Description : AxiomaCore-328 6-bit I/O register bus bundle used by the
//               ADC scan sequencer.
//   io_addr     - register address        (master -> slave)
//   io_data_in  - write data              (master -> slave)
//   io_read     - one-cycle read strobe   (master -> slave)
//   io_write    - one-cycle write strobe  (master -> slave)
//   io_data_out - combinational read data (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface axioma_adc_seq_if;
  logic [5:0] io_addr;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;
  logic       io_read;
  logic       io_write;

  modport master (
    output io_addr,
    output io_data_in,
    output io_read,
    output io_write,
    input  io_data_out
  );

  modport slave (
    input  io_addr,
    input  io_data_in,
    input  io_read,
    input  io_write,
    output io_data_out
  );
endinterface
`default_nettype wire

// File: rtl/axioma_adc_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axioma_adc_seq
// Description : Multi-channel ADC scan sequencer. Walks the enabled channels
//               in ascending order, converts each one and pushes
//               {channel, result} entries into a result FIFO.
// Ports       :
//   clk           - system clock
//   reset_n       - synchronous active-low reset
//   bus           - I/O register bus (slave side)
//   ch_sample     - per-channel digitised values, channel k at [k*RES_BITS +: RES_BITS]
//   adc_trigger   - external start trigger (rising edge)
//   adc_interrupt - level interrupt, IE & (DONE | OVR)
//   debug_state   - {state[2:0], busy, cur_ch[3:0]}
// Options     : AXIOMA_ADC_AVG_EN - per-channel averaging of 1/2/4/8 samples
// Revision    : 1.0 - initial release
// ============================================================================
module axioma_adc_seq #(
  parameter int NUM_CH     = 8,
  parameter int RES_BITS   = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CONV_CLKS  = 13
) (
  input  logic                       clk,
  input  logic                       reset_n,
  axioma_adc_seq_if.slave            bus,
  input  logic [NUM_CH*RES_BITS-1:0] ch_sample,
  input  logic                       adc_trigger,
  output logic                       adc_interrupt,
  output logic [7:0]                 debug_state
);

  localparam int         FAW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         ENTRY_W     = RES_BITS + 4;
  localparam logic [7:0] CONV_LAST   = 8'(CONV_CLKS - 1);
  localparam logic [5:0] ADDR_CTRL   = 6'h30;
  localparam logic [5:0] ADDR_MASK   = 6'h31;
  localparam logic [5:0] ADDR_PRESC  = 6'h32;
  localparam logic [5:0] ADDR_STATUS = 6'h33;
  localparam logic [5:0] ADDR_DATAL  = 6'h34;
  localparam logic [5:0] ADDR_DATAH  = 6'h35;
  localparam logic [5:0] ADDR_AVG    = 6'h36;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CONVERT = 3'd2,
    S_STORE   = 3'd3,
    S_NEXT    = 3'd4
  } state_e;

  // Registers
  state_e              state_q;
  logic                en_q, start_q, cont_q, trigen_q, ie_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [7:0]          presc_q;
  logic                done_q, ovr_q;
  logic                trig_q;
  logic [3:0]          cur_ch_q;
  logic [7:0]          presc_cnt_q;
  logic [7:0]          tick_cnt_q;

  logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [FAW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FAW:0]        count_q;

  // Combinational
  logic                w_wr_ctrl, w_wr_mask, w_wr_presc, w_wr_status;
  logic                w_busy, w_full, w_empty;
  logic                w_tick, w_smp_latch, w_conv_done, w_last_smp;
  logic                w_abort, w_trig_rise, w_start_req, w_start;
  logic                w_push, w_push_ok, w_pop, w_scan_end;
  logic                w_mask_nz, w_next_found;
  logic [3:0]          w_next_ch, w_low_ch;
  logic [RES_BITS-1:0] w_cur_sample, w_store_val;
  logic [ENTRY_W-1:0]  w_head;
  logic [11:0]         w_head_res12;
  logic [7:0]          w_avg_rd;

  assign w_wr_ctrl   = bus.io_write && (bus.io_addr == ADDR_CTRL);
  assign w_wr_mask   = bus.io_write && (bus.io_addr == ADDR_MASK);
  assign w_wr_presc  = bus.io_write && (bus.io_addr == ADDR_PRESC);
  assign w_wr_status = bus.io_write && (bus.io_addr == ADDR_STATUS);

  assign w_busy  = (state_q != S_IDLE);
  assign w_full  = (count_q == (FAW+1)'(FIFO_DEPTH));
  assign w_empty = (count_q == '0);

  // >= rather than == so a PRESC write below the running count still ticks.
  assign w_tick      = (presc_cnt_q >= presc_q);
  assign w_smp_latch = (state_q == S_SAMPLE)  && w_tick && (tick_cnt_q == 8'd1);
  assign w_conv_done = (state_q == S_CONVERT) && w_tick && (tick_cnt_q == CONV_LAST);

  assign w_cur_sample = ch_sample[cur_ch_q*RES_BITS +: RES_BITS];

  // Clearing EN dominates everything else in the same cycle.
  assign w_abort     = w_wr_ctrl && !bus.io_data_in[7];
  assign w_trig_rise = adc_trigger && !trig_q;
  assign w_start_req = (w_wr_ctrl && bus.io_data_in[7] && bus.io_data_in[6]) ||
                       (w_trig_rise && trigen_q && en_q);
  assign w_start     = (state_q == S_IDLE) && w_start_req && w_mask_nz && !w_abort;

  assign w_push     = (state_q == S_STORE) && !w_abort;
  assign w_push_ok  = w_push && !w_full;
  assign w_pop      = bus.io_read && (bus.io_addr == ADDR_DATAH) && !w_empty;
  assign w_scan_end = (state_q == S_NEXT) && !w_abort && !w_next_found;

  // Lowest set mask bit, and lowest set bit strictly above cur_ch.
  always_comb begin
    w_next_found = 1'b0;
    w_next_ch    = 4'd0;
    w_low_ch     = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        w_low_ch = 4'(i);
      end
      if (mask_q[i] && (i > int'(cur_ch_q))) begin
        w_next_found = 1'b1;
        w_next_ch    = 4'(i);
      end
    end
  end
  assign w_mask_nz = |mask_q;

`ifdef AXIOMA_ADC_AVG_EN
  localparam int ACC_W = RES_BITS + 3;

  logic [1:0]       avg_q;
  logic [ACC_W-1:0] acc_q;
  logic [2:0]       smp_cnt_q;
  logic             w_wr_avg;

  assign w_wr_avg    = bus.io_write && (bus.io_addr == ADDR_AVG);
  assign w_last_smp  = (({1'b0, smp_cnt_q} + 4'd1) == (4'd1 << avg_q));
  assign w_store_val = RES_BITS'(acc_q >> avg_q);
  assign w_avg_rd    = {6'd0, avg_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avg_q     <= 2'd0;
      acc_q     <= '0;
      smp_cnt_q <= 3'd0;
    end else begin
      if (w_wr_avg) begin
        avg_q <= bus.io_data_in[1:0];
      end
      // First sample of a channel restarts the sum.
      if (w_smp_latch) begin
        acc_q <= (smp_cnt_q == 3'd0) ? ACC_W'(w_cur_sample)
                                     : acc_q + ACC_W'(w_cur_sample);
      end
      if (state_q == S_IDLE || state_q == S_STORE) begin
        smp_cnt_q <= 3'd0;
      end else if (w_conv_done) begin
        smp_cnt_q <= smp_cnt_q + 3'd1;
      end
    end
  end
`else
  logic [RES_BITS-1:0] smp_q;

  assign w_last_smp  = 1'b1;
  assign w_store_val = smp_q;
  assign w_avg_rd    = 8'h00;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      smp_q <= '0;
    end else if (w_smp_latch) begin
      smp_q <= w_cur_sample;
    end
  end
`endif

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {cur_ch_q, w_store_val};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) begin
        wr_ptr_q <= wr_ptr_q + FAW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + FAW'(1);
      end
      count_q <= count_q + (FAW+1)'(w_push_ok) - (FAW+1)'(w_pop);
    end
  end

  assign w_head       = fifo_mem_q[rd_ptr_q];
  assign w_head_res12 = 12'(w_head[RES_BITS-1:0]);

  // Registers, flags and scan state machine
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      trigen_q    <= 1'b0;
      ie_q        <= 1'b0;
      mask_q      <= '0;
      presc_q     <= 8'd0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      trig_q      <= 1'b0;
      cur_ch_q    <= 4'd0;
      presc_cnt_q <= 8'd0;
      tick_cnt_q  <= 8'd0;
    end else begin
      trig_q <= adc_trigger;

      if (w_wr_ctrl) begin
        en_q     <= bus.io_data_in[7];
        cont_q   <= bus.io_data_in[5];
        trigen_q <= bus.io_data_in[4];
        ie_q     <= bus.io_data_in[3];
      end
      if (w_wr_mask) begin
        mask_q <= bus.io_data_in[NUM_CH-1:0];
      end
      if (w_wr_presc) begin
        presc_q <= bus.io_data_in;
      end

      // Hardware set is applied after the W1C so it wins on a collision.
      if (w_wr_status && bus.io_data_in[0]) begin
        done_q <= 1'b0;
      end
      if (w_wr_status && bus.io_data_in[1]) begin
        ovr_q <= 1'b0;
      end
      if (w_scan_end) begin
        done_q <= 1'b1;
      end
      if (w_push && w_full) begin
        ovr_q <= 1'b1;
      end

      if (w_abort) begin
        state_q <= S_IDLE;
        start_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (w_start) begin
              state_q     <= S_SAMPLE;
              start_q     <= 1'b1;
              cur_ch_q    <= w_low_ch;
              presc_cnt_q <= 8'd0;
              tick_cnt_q  <= 8'd0;
            end
          end
          S_SAMPLE: begin
            if (w_tick) begin
              presc_cnt_q <= 8'd0;
              if (tick_cnt_q == 8'd1) begin
                state_q    <= S_CONVERT;
                tick_cnt_q <= 8'd0;
              end else begin
                tick_cnt_q <= tick_cnt_q + 8'd1;
              end
            end else begin
              presc_cnt_q <= presc_cnt_q + 8'd1;
            end
          end
          S_CONVERT: begin
            if (w_tick) begin
              presc_cnt_q <= 8'd0;
              if (tick_cnt_q == CONV_LAST) begin
                tick_cnt_q <= 8'd0;
                state_q    <= w_last_smp ? S_STORE : S_SAMPLE;
              end else begin
                tick_cnt_q <= tick_cnt_q + 8'd1;
              end
            end else begin
              presc_cnt_q <= presc_cnt_q + 8'd1;
            end
          end
          S_STORE: begin
            state_q <= S_NEXT;
          end
          S_NEXT: begin
            presc_cnt_q <= 8'd0;
            tick_cnt_q  <= 8'd0;
            if (w_next_found) begin
              cur_ch_q <= w_next_ch;
              state_q  <= S_SAMPLE;
            end else if (cont_q && w_mask_nz) begin
              cur_ch_q <= w_low_ch;
              state_q  <= S_SAMPLE;
            end else begin
              state_q <= S_IDLE;
              start_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register read mux; FIFO head reads as 0 while empty.
  always_comb begin
    bus.io_data_out = 8'h00;
    if (bus.io_read) begin
      case (bus.io_addr)
        ADDR_CTRL:   bus.io_data_out = {en_q, start_q, cont_q, trigen_q, ie_q, 3'b000};
        ADDR_MASK:   bus.io_data_out = 8'(mask_q);
        ADDR_PRESC:  bus.io_data_out = presc_q;
        ADDR_STATUS: bus.io_data_out = {w_busy, w_full, w_empty, 3'b000, ovr_q, done_q};
        ADDR_DATAL:  bus.io_data_out = w_empty ? 8'h00 : w_head_res12[7:0];
        ADDR_DATAH:  bus.io_data_out = w_empty ? 8'h00 :
                                       {w_head[ENTRY_W-1:RES_BITS], w_head_res12[11:8]};
        ADDR_AVG:    bus.io_data_out = w_avg_rd;
        default:     bus.io_data_out = 8'h00;
      endcase
    end
  end

  assign adc_interrupt = ie_q & (done_q | ovr_q);
  assign debug_state   = {state_q, w_busy, cur_ch_q};

endmodule
`default_nettype wire

// File: tb/tb_axioma_adc_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axioma_adc_seq
// Description : Directed self-checking bench for axioma_adc_seq (default
//               parameters). Averaging expectations follow AXIOMA_ADC_AVG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axioma_adc_seq;
  localparam int NUM_CH   = 8;
  localparam int RES_BITS = 10;

  localparam logic [5:0] A_CTRL   = 6'h30;
  localparam logic [5:0] A_MASK   = 6'h31;
  localparam logic [5:0] A_PRESC  = 6'h32;
  localparam logic [5:0] A_STATUS = 6'h33;
  localparam logic [5:0] A_DATAL  = 6'h34;
  localparam logic [5:0] A_DATAH  = 6'h35;
  localparam logic [5:0] A_AVG    = 6'h36;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [NUM_CH*RES_BITS-1:0] ch_sample = '0;
  logic                       adc_trigger = 1'b0;
  logic                       adc_interrupt;
  logic [7:0]                 debug_state;

  axioma_adc_seq_if bus ();

  axioma_adc_seq #(
    .NUM_CH    (NUM_CH),
    .RES_BITS  (RES_BITS),
    .FIFO_DEPTH(4),
    .CONV_CLKS (13)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .ch_sample    (ch_sample),
    .adc_trigger  (adc_trigger),
    .adc_interrupt(adc_interrupt),
    .debug_state  (debug_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [RES_BITS-1:0] v);
    ch_sample[k*RES_BITS +: RES_BITS] = v;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.io_addr = a; bus.io_data_in = d; bus.io_write = 1'b1;
    @(negedge clk);
    bus.io_write = 1'b0;
  endtask

  // Read with a clock edge (pops when addressing DATAH).
  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.io_addr = a; bus.io_read = 1'b1;
    #1 d = bus.io_data_out;
    @(negedge clk);
    bus.io_read = 1'b0;
  endtask

  // Combinational look at a register without letting a clock edge see the strobe.
  task automatic peek(input logic [5:0] a, output logic [7:0] d);
    bus.io_addr = a; bus.io_read = 1'b1;
    #1 d = bus.io_data_out;
    bus.io_read = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (debug_state[7:5] != st && n < budget) begin
      @(negedge clk); n++;
    end
    chk(tag, (n < budget) ? 8'h01 : 8'h00, 8'h01);
  endtask

  task automatic wait_nonempty(input string tag, input int budget);
    int n = 0;
    logic [7:0] s;
    peek(A_STATUS, s);
    while (s[5] && n < budget) begin
      @(negedge clk); n++; peek(A_STATUS, s);
    end
    chk(tag, (n < budget) ? 8'h01 : 8'h00, 8'h01);
  endtask

  logic [7:0] d;
  int         n;
  logic [2:0] prev_st;
  logic [RES_BITS-1:0] v;
  logic [7:0] exp_l [4] = '{8'h55, 8'hAA, 8'hAA, 8'hC3};
  logic [7:0] exp_h [4] = '{8'h01, 8'h10, 8'h22, 8'h33};

  initial begin
    bus.io_addr = 6'h00; bus.io_data_in = 8'h00; bus.io_read = 1'b0; bus.io_write = 1'b0;
    set_ch(0, 10'h155); set_ch(1, 10'h0AA); set_ch(2, 10'h2AA); set_ch(3, 10'h3C3);
    set_ch(4, 10'h011); set_ch(5, 10'h022); set_ch(6, 10'h033); set_ch(7, 10'h3FF);

    // ---- Reset state
    repeat (3) @(negedge clk);
    chk("rst_debug", debug_state, 8'h00);
    chk("rst_irq", {7'd0, adc_interrupt}, 8'h00);
    chk("rst_dout_noread", bus.io_data_out, 8'h00);
    peek(A_STATUS, d); chk("rst_status", d, 8'h20);
    peek(A_CTRL, d);   chk("rst_ctrl", d, 8'h00);
    reset_n = 1'b1;

    // ---- Single scan, MASK=0x05, PRESC=0
    wr(A_MASK, 8'h05);
    wr(A_PRESC, 8'h00);
    wr(A_CTRL, 8'hC0);                       // start write at cycle T; now in T+1
    chk("scan_sample_entry", debug_state, 8'h30);
    peek(A_CTRL, d); chk("scan_ctrl_busy", d, 8'hC0);
    repeat (15) @(negedge clk);              // cycle T+16
    peek(A_STATUS, d); chk("scan_empty_at_T16", d & 8'h20, 8'h20);
    @(negedge clk);                          // cycle T+17
    peek(A_STATUS, d); chk("scan_nonempty_at_T17", d & 8'h20, 8'h00);
    wait_state("scan_idle_timeout", 3'd0, 100);
    peek(A_STATUS, d); chk("scan_status_done", d, 8'h01);
    peek(A_CTRL, d);   chk("scan_start_cleared", d, 8'h80);
    peek(A_DATAL, d);  chk("scan_datal0", d, 8'h55);
    rd(A_DATAH, d);    chk("scan_datah0", d, 8'h01);
    peek(A_DATAL, d);  chk("scan_datal1", d, 8'hAA);
    rd(A_DATAH, d);    chk("scan_datah1", d, 8'h22);
    rd(A_DATAH, d);    chk("scan_datah_empty", d, 8'h00);
    peek(A_STATUS, d); chk("scan_status_drained", d, 8'h21);
    wr(A_STATUS, 8'h01);
    peek(A_STATUS, d); chk("scan_done_w1c", d, 8'h20);

    // ---- Overrun, MASK=0x3F with IE
    wr(A_MASK, 8'h3F);
    wr(A_CTRL, 8'hC8);
    wait_state("ovr_idle_timeout", 3'd0, 300);
    peek(A_STATUS, d); chk("ovr_status", d, 8'h43);
    chk("ovr_irq_set", {7'd0, adc_interrupt}, 8'h01);
    wr(A_STATUS, 8'h03);
    peek(A_STATUS, d); chk("ovr_status_w1c", d, 8'h40);
    chk("ovr_irq_clear", {7'd0, adc_interrupt}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      peek(A_DATAL, d); chk($sformatf("ovr_datal%0d", i), d, exp_l[i]);
      rd(A_DATAH, d);   chk($sformatf("ovr_datah%0d", i), d, exp_h[i]);
    end
    peek(A_STATUS, d); chk("ovr_drained", d, 8'h20);

    // ---- Continuous on ch7, then abort mid-CONVERT
    wr(A_MASK, 8'h80);
    wr(A_CTRL, 8'hE0);
    peek(A_CTRL, d); chk("cont_ctrl", d, 8'hE0);
    for (int k = 0; k < 3; k++) begin
      wait_nonempty($sformatf("cont_wait%0d", k), 100);
      peek(A_DATAL, d); chk($sformatf("cont_datal%0d", k), d, 8'hFF);
      rd(A_DATAH, d);   chk($sformatf("cont_datah%0d", k), d, 8'h73);
    end
    wait_state("cont_convert_timeout", 3'd2, 100);
    wr(A_CTRL, 8'h00);
    chk("abort_idle_next", debug_state & 8'hF0, 8'h00);
    repeat (40) @(negedge clk);
    peek(A_STATUS, d); chk("abort_no_entry", d, 8'h21);
    peek(A_CTRL, d);   chk("abort_ctrl", d, 8'h00);
    wr(A_STATUS, 8'h03);

    // ---- Trigger, PRESC=1, MASK=0x06, second pulse while busy
    wr(A_PRESC, 8'h01);
    wr(A_MASK, 8'h06);
    wr(A_CTRL, 8'h90);
    chk("trig_armed_idle", debug_state & 8'hF0, 8'h00);
    @(negedge clk); adc_trigger = 1'b1;
    @(negedge clk); adc_trigger = 1'b0;       // cycle T+1
    chk("trig_started", debug_state, 8'h31);
    n = 1;
    peek(A_STATUS, d);
    while (d[5] && n < 200) begin
      adc_trigger = (n == 5);
      @(negedge clk); n++;
      peek(A_STATUS, d);
    end
    adc_trigger = 1'b0;
    chk("trig_first_result_cycle", 8'(n), 8'd32);
    wait_state("trig_idle_timeout", 3'd0, 300);
    repeat (20) @(negedge clk);
    chk("trig_stays_idle", debug_state & 8'hF0, 8'h00);
    peek(A_STATUS, d); chk("trig_status", d, 8'h01);
    peek(A_DATAL, d);  chk("trig_datal0", d, 8'hAA);
    rd(A_DATAH, d);    chk("trig_datah0", d, 8'h10);
    peek(A_DATAL, d);  chk("trig_datal1", d, 8'hAA);
    rd(A_DATAH, d);    chk("trig_datah1", d, 8'h22);
    peek(A_STATUS, d); chk("trig_two_entries", d, 8'h21);

    // ---- Averaging: ch1 sequence 100,101,102,103
    wr(A_STATUS, 8'h03);
    wr(A_PRESC, 8'h00);
    wr(A_AVG, 8'h02);
    peek(A_AVG, d);
`ifdef AXIOMA_ADC_AVG_EN
    chk("avg_readback", d, 8'h02);
`else
    chk("avg_readback", d, 8'h00);
`endif
    v = 10'd100;
    set_ch(1, v);
    wr(A_MASK, 8'h02);
    wr(A_CTRL, 8'hC0);
    prev_st = debug_state[7:5];
    n = 0;
    while (debug_state[7:5] != 3'd0 && n < 400) begin
      @(negedge clk); n++;
      if (debug_state[7:5] == 3'd2 && prev_st != 3'd2) begin
        v = v + 10'd1;
        set_ch(1, v);
      end
      prev_st = debug_state[7:5];
    end
    chk("avg_idle_timeout", (n < 400) ? 8'h01 : 8'h00, 8'h01);
    peek(A_DATAL, d);
`ifdef AXIOMA_ADC_AVG_EN
    chk("avg_datal", d, 8'd101);
`else
    chk("avg_datal", d, 8'd100);
`endif
    rd(A_DATAH, d); chk("avg_datah", d, 8'h10);

    // ---- Reset during CONVERT
    wr(A_MASK, 8'h01);
    wr(A_CTRL, 8'hC8);
    chk("pre_reset_irq", {7'd0, adc_interrupt}, 8'h01);
    wait_state("rst_convert_timeout", 3'd2, 50);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_debug", debug_state, 8'h00);
    chk("mid_rst_irq", {7'd0, adc_interrupt}, 8'h00);
    peek(A_STATUS, d); chk("mid_rst_status", d, 8'h20);
    peek(A_CTRL, d);   chk("mid_rst_ctrl", d, 8'h00);
    peek(A_MASK, d);   chk("mid_rst_mask", d, 8'h00);
    peek(A_PRESC, d);  chk("mid_rst_presc", d, 8'h00);
    repeat (30) @(negedge clk);
    peek(A_STATUS, d); chk("mid_rst_no_store", d, 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
